// File: rtl/sap_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sap_ctrl_pkg
// Shared definitions for the SAP control sequencer.
//   - opcode values (4-bit canonical form after normalisation)
//   - bit positions inside the 16-bit datapath control word
//   - CTRL_IDLE: every active-high strobe low, every active-low strobe high
//   - stage_t: encoding of the sequencer stage register
// ---------------------------------------------------------------------------
package sap_ctrl_pkg;

    localparam int CTRL_W  = 16;
    localparam int STAGE_W = 4;

    // Opcodes
    localparam logic [3:0] OP_HLT = 4'd0;
    localparam logic [3:0] OP_NOP = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_LDA = 4'd4;
    localparam logic [3:0] OP_OUT = 4'd5;
    localparam logic [3:0] OP_STA = 4'd6;
    localparam logic [3:0] OP_JMP = 4'd7;
    localparam logic [3:0] OP_JC  = 4'd8;
    localparam logic [3:0] OP_JZ  = 4'd9;

    // Control word bit indices (_N = active low)
    localparam int CTRL_FLAGS_LOAD      = 15;
    localparam int CTRL_PC_INC          = 14;
    localparam int CTRL_PC_EN           = 13;
    localparam int CTRL_PC_LOAD         = 12;
    localparam int CTRL_MAR_ADDR_LOAD_N = 11;
    localparam int CTRL_MAR_MEM_LOAD_N  = 10;
    localparam int CTRL_RAM_EN_N        = 9;
    localparam int CTRL_RAM_LOAD_N      = 8;
    localparam int CTRL_IR_LOAD_N       = 7;
    localparam int CTRL_IR_EN_N         = 6;
    localparam int CTRL_REGA_LOAD_N     = 5;
    localparam int CTRL_REGA_EN         = 4;
    localparam int CTRL_ADDER_SUB       = 3;
    localparam int CTRL_REGB_EN         = 2;
    localparam int CTRL_REGB_LOAD_N     = 1;
    localparam int CTRL_OUT_LOAD_N      = 0;

    localparam logic [CTRL_W-1:0] CTRL_IDLE = 16'h0FE3;

    // Stage encodings; unlisted values are illegal and recover via HOLD
    typedef enum logic [STAGE_W-1:0] {
        ST_T0        = 4'd0,
        ST_T1        = 4'd1,
        ST_T2        = 4'd2,
        ST_T3        = 4'd3,
        ST_T4        = 4'd4,
        ST_T5        = 4'd5,
        ST_HOLD      = 4'd8,
        ST_HALT      = 4'd9,
        ST_WAIT_STEP = 4'd10
    } stage_t;

endpackage

// File: rtl/sap_ctrl_seq_if.sv
// ---------------------------------------------------------------------------
// sap_ctrl_seq_if
// Bundle between the IR/flags/front-panel side and the control sequencer.
//   master : drives opcode_i, flag_c_i, flag_z_i, run_i, step_i, resume_i
//            and observes ctrl_o, stage_o, halted_o, instr_done_o
//   slave  : the sequencer (inverse directions)
// ---------------------------------------------------------------------------
interface sap_ctrl_seq_if
    import sap_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4
);
    logic [OPCODE_W-1:0] opcode_i;
    logic                flag_c_i;
    logic                flag_z_i;
    logic                run_i;
    logic                step_i;
    logic                resume_i;
    logic [CTRL_W-1:0]   ctrl_o;
    logic [STAGE_W-1:0]  stage_o;
    logic                halted_o;
    logic                instr_done_o;

    modport master (
        output opcode_i, flag_c_i, flag_z_i, run_i, step_i, resume_i,
        input  ctrl_o, stage_o, halted_o, instr_done_o
    );

    modport slave (
        input  opcode_i, flag_c_i, flag_z_i, run_i, step_i, resume_i,
        output ctrl_o, stage_o, halted_o, instr_done_o
    );
endinterface

// File: rtl/sap_ctrl_decode.sv
// ---------------------------------------------------------------------------
// sap_ctrl_decode
// Purely combinational map from (stage, opcode, flags) to the control word.
//   i_stage      : current stage register value
//   i_opcode     : IR opcode field (unsupported values behave as NOP)
//   i_flag_c/z   : carry / zero flags, used by JC / JZ in T3
//   o_ctrl       : 16-bit control word
//   o_instr_done : high in the final stage of the instruction
//   o_last       : same condition, used by the next-stage logic
//   o_to_halt    : final stage of HLT, next stage is HALT
// ---------------------------------------------------------------------------
module sap_ctrl_decode
    import sap_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input  stage_t              i_stage,
    input  logic [OPCODE_W-1:0] i_opcode,
    input  logic                i_flag_c,
    input  logic                i_flag_z,
    output logic [CTRL_W-1:0]   o_ctrl,
    output logic                o_instr_done,
    output logic                o_last,
    output logic                o_to_halt
);

    logic       w_upper_set;
    logic [3:0] w_op;
    stage_t     w_last_stage;

    generate
        if (OPCODE_W > 4) begin : g_upper
            assign w_upper_set = |i_opcode[OPCODE_W-1:4];
        end else begin : g_no_upper
            assign w_upper_set = 1'b0;
        end
    endgenerate

    // Anything outside the defined opcode set is folded onto NOP
    assign w_op = (w_upper_set || (i_opcode[3:0] > OP_JZ)) ? OP_NOP : i_opcode[3:0];

    always_comb begin
        w_last_stage = ST_T2;
        case (w_op)
            OP_HLT, OP_OUT, OP_JMP, OP_JC, OP_JZ: w_last_stage = ST_T3;
            OP_LDA:                               w_last_stage = ST_T4;
            OP_ADD, OP_SUB, OP_STA:               w_last_stage = ST_T5;
            default:                              w_last_stage = ST_T2;
        endcase
    end

    // ">=" rather than "==" so an opcode changing mid-instruction still ends it
    assign o_last       = (i_stage <= ST_T5) && (i_stage >= w_last_stage);
    assign o_instr_done = o_last;
    assign o_to_halt    = o_last && (w_op == OP_HLT);

    always_comb begin
        o_ctrl = CTRL_IDLE;
        case (i_stage)
            ST_T0: begin
                o_ctrl[CTRL_PC_EN]          = 1'b1;
                o_ctrl[CTRL_MAR_ADDR_LOAD_N] = 1'b0;
            end
            ST_T1: o_ctrl[CTRL_PC_INC] = 1'b1;
            ST_T2: begin
                o_ctrl[CTRL_RAM_EN_N]  = 1'b0;
                o_ctrl[CTRL_IR_LOAD_N] = 1'b0;
            end
            ST_T3: begin
                case (w_op)
                    OP_OUT: begin
                        o_ctrl[CTRL_REGA_EN]    = 1'b1;
                        o_ctrl[CTRL_OUT_LOAD_N] = 1'b0;
                    end
                    OP_JMP, OP_JC, OP_JZ: begin
                        if ((w_op == OP_JMP) || (w_op == OP_JC && i_flag_c) ||
                            (w_op == OP_JZ && i_flag_z)) begin
                            o_ctrl[CTRL_IR_EN_N]  = 1'b0;
                            o_ctrl[CTRL_PC_LOAD]  = 1'b1;
                        end
                    end
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        o_ctrl[CTRL_IR_EN_N]         = 1'b0;
                        o_ctrl[CTRL_MAR_ADDR_LOAD_N] = 1'b0;
                    end
                    default: ;
                endcase
            end
            ST_T4: begin
                case (w_op)
                    OP_LDA: begin
                        o_ctrl[CTRL_RAM_EN_N]    = 1'b0;
                        o_ctrl[CTRL_REGA_LOAD_N] = 1'b0;
                    end
                    OP_ADD, OP_SUB: begin
                        o_ctrl[CTRL_RAM_EN_N]    = 1'b0;
                        o_ctrl[CTRL_REGB_LOAD_N] = 1'b0;
                    end
                    OP_STA: begin
                        o_ctrl[CTRL_REGA_EN]        = 1'b1;
                        o_ctrl[CTRL_MAR_MEM_LOAD_N] = 1'b0;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (w_op)
                    OP_ADD, OP_SUB: begin
                        o_ctrl[CTRL_REGB_EN]     = 1'b1;
                        o_ctrl[CTRL_REGA_LOAD_N] = 1'b0;
                        o_ctrl[CTRL_FLAGS_LOAD]  = 1'b1;
                        o_ctrl[CTRL_ADDER_SUB]   = (w_op == OP_SUB);
                    end
                    OP_STA: o_ctrl[CTRL_RAM_LOAD_N] = 1'b0;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sap_ctrl_seq.sv
// ---------------------------------------------------------------------------
// sap_ctrl_seq
// SAP control sequencer: stage register plus next-stage logic; the control
// word is decoded from the registered stage by sap_ctrl_decode.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset (stage forced to HOLD)
//   bus   : sap_ctrl_seq_if.slave (opcode/flags/run/step/resume in,
//           ctrl/stage/halted/instr_done out)
// run_i, step_i and resume_i only influence the next stage, never an output
// in the same cycle.
// ---------------------------------------------------------------------------
module sap_ctrl_seq
    import sap_ctrl_pkg::*;
#(
    parameter int OPCODE_W  = 4,
    parameter int STEP_EN   = 1,
    parameter int RESUME_EN = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    sap_ctrl_seq_if.slave  bus
);

    stage_t            r_stage;
    logic              r_step_used;
    logic [CTRL_W-1:0] w_ctrl;
    logic              w_instr_done;
    logic              w_last;
    logic              w_to_halt;

    sap_ctrl_decode #(.OPCODE_W(OPCODE_W)) u_decode (
        .i_stage      (r_stage),
        .i_opcode     (bus.opcode_i),
        .i_flag_c     (bus.flag_c_i),
        .i_flag_z     (bus.flag_z_i),
        .o_ctrl       (w_ctrl),
        .o_instr_done (w_instr_done),
        .o_last       (w_last),
        .o_to_halt    (w_to_halt)
    );

    // r_step_used marks a step_i level that already released WAIT_STEP; it
    // clears only once step_i drops, so a held step advances one instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stage     <= ST_HOLD;
            r_step_used <= 1'b0;
        end else begin
            if (!bus.step_i) begin
                r_step_used <= 1'b0;
            end
            case (r_stage)
                ST_HOLD: r_stage <= ST_T0;
                ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5: begin
                    if (w_to_halt) begin
                        r_stage <= ST_HALT;
                    end else if (w_last) begin
                        if ((STEP_EN != 0) && !bus.run_i) begin
                            r_stage <= ST_WAIT_STEP;
                        end else begin
                            r_stage <= ST_T0;
                        end
                    end else begin
                        r_stage <= stage_t'(r_stage + 4'd1);
                    end
                end
                ST_HALT: begin
                    if ((RESUME_EN != 0) && bus.resume_i) begin
                        r_stage <= ST_T0;
                    end
                end
                ST_WAIT_STEP: begin
                    if ((STEP_EN == 0) || bus.run_i) begin
                        r_stage <= ST_T0;
                    end else if (bus.step_i && !r_step_used) begin
                        r_stage     <= ST_T0;
                        r_step_used <= 1'b1;
                    end
                end
                default: r_stage <= ST_HOLD;
            endcase
        end
    end

    assign bus.ctrl_o       = w_ctrl;
    assign bus.stage_o      = r_stage;
    assign bus.halted_o     = (r_stage == ST_HALT);
    assign bus.instr_done_o = w_instr_done;

endmodule

// File: tb/tb_sap_ctrl_seq.sv
// ---------------------------------------------------------------------------
// tb_sap_ctrl_seq
// Each cycle the stimulus drives inputs just after the rising edge and pushes
// the outputs expected for that cycle; a monitor pops and compares on the
// falling edge. A second instance with a 6-bit opcode checks folding to NOP.
// ---------------------------------------------------------------------------
module tb_sap_ctrl_seq;

    localparam logic [15:0] IDLE   = 16'h0FE3;
    localparam logic [15:0] F0     = 16'h27E3;
    localparam logic [15:0] F1     = 16'h4FE3;
    localparam logic [15:0] F2     = 16'h0D63;
    localparam logic [15:0] X3_MEM = 16'h07A3;
    localparam logic [15:0] JMP3   = 16'h1FA3;
    localparam logic [15:0] OUT3   = 16'h0FF2;
    localparam logic [15:0] LDA4   = 16'h0DC3;
    localparam logic [15:0] ADD4   = 16'h0DE1;
    localparam logic [15:0] ADD5   = 16'h8FC7;
    localparam logic [15:0] SUB5   = 16'h8FCF;
    localparam logic [15:0] STA4   = 16'h0BF3;
    localparam logic [15:0] STA5   = 16'h0EE3;

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] ctrl;
        logic        h;
        logic        d;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_row = 0;
    logic chk6 = 1'b0;
    exp_t q[$];
    exp_t q6[$];

    always #5 clk = ~clk;

    sap_ctrl_seq_if #(.OPCODE_W(4)) bus ();
    sap_ctrl_seq_if #(.OPCODE_W(6)) bus6 ();

    sap_ctrl_seq #(.OPCODE_W(4), .STEP_EN(1), .RESUME_EN(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    sap_ctrl_seq #(.OPCODE_W(6), .STEP_EN(1), .RESUME_EN(1)) dut6 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus6.slave)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs after the edge, record what this cycle must show
    task automatic cyc(input logic r, input logic [3:0] op, input logic cf, input logic zf,
                       input logic run, input logic step, input logic res,
                       input logic [3:0] st, input logic [15:0] ctrl, input logic h, input logic d);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n         = r;
        bus.opcode_i  = op;
        bus.flag_c_i  = cf;
        bus.flag_z_i  = zf;
        bus.run_i     = run;
        bus.step_i    = step;
        bus.resume_i  = res;
        bus6.flag_c_i = cf;
        bus6.flag_z_i = zf;
        bus6.run_i    = run;
        bus6.step_i   = step;
        bus6.resume_i = res;
        e = '{st: st, ctrl: ctrl, h: h, d: d};
        q.push_back(e);
        if (chk6) q6.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_row++;
            $display("row %0d: stage=%0d ctrl=%h halted=%b done=%b", n_row,
                     bus.stage_o, bus.ctrl_o, bus.halted_o, bus.instr_done_o);
            check_val($sformatf("stage@%0d", n_row), 32'(bus.stage_o), 32'(e.st));
            check_val($sformatf("ctrl@%0d", n_row), 32'(bus.ctrl_o), 32'(e.ctrl));
            check_val($sformatf("halted@%0d", n_row), 32'(bus.halted_o), 32'(e.h));
            check_val($sformatf("done@%0d", n_row), 32'(bus.instr_done_o), 32'(e.d));
        end
        if (q6.size() > 0) begin
            e = q6.pop_front();
            $display("w6 row: op6=%h stage=%0d done=%b", bus6.opcode_i, bus6.stage_o, bus6.instr_done_o);
            check_val("w6_stage", 32'(bus6.stage_o), 32'(e.st));
            check_val("w6_done", 32'(bus6.instr_done_o), 32'(e.d));
        end
    end

    initial begin
        rst_n = 1'b0;
        bus.opcode_i = 4'd2;  bus.flag_c_i = 1'b0; bus.flag_z_i = 1'b0;
        bus.run_i = 1'b1;     bus.step_i = 1'b0;   bus.resume_i = 1'b0;
        bus6.opcode_i = 6'h12; bus6.flag_c_i = 1'b0; bus6.flag_z_i = 1'b0;
        bus6.run_i = 1'b1;    bus6.step_i = 1'b0;  bus6.resume_i = 1'b0;

        // Reset, then ADD free-running
        cyc(0, 2, 0, 0, 1, 0, 0, 8, IDLE, 0, 0);
        cyc(1, 2, 0, 0, 1, 0, 0, 8, IDLE, 0, 0);
        cyc(1, 2, 0, 0, 1, 0, 0, 0, F0, 0, 0);
        cyc(1, 2, 0, 0, 1, 0, 0, 1, F1, 0, 0);
        cyc(1, 2, 0, 0, 1, 0, 0, 2, F2, 0, 0);
        cyc(1, 2, 0, 0, 1, 0, 0, 3, X3_MEM, 0, 0);
        cyc(1, 2, 0, 0, 1, 0, 0, 4, ADD4, 0, 0);
        cyc(1, 2, 0, 0, 1, 0, 0, 5, ADD5, 0, 1);
        // JC taken
        cyc(1, 8, 1, 0, 1, 0, 0, 0, F0, 0, 0);
        cyc(1, 8, 1, 0, 1, 0, 0, 1, F1, 0, 0);
        cyc(1, 8, 1, 0, 1, 0, 0, 2, F2, 0, 0);
        cyc(1, 8, 1, 0, 1, 0, 0, 3, JMP3, 0, 1);
        // JC not taken
        cyc(1, 8, 0, 1, 1, 0, 0, 0, F0, 0, 0);
        cyc(1, 8, 0, 1, 1, 0, 0, 1, F1, 0, 0);
        cyc(1, 8, 0, 1, 1, 0, 0, 2, F2, 0, 0);
        cyc(1, 8, 0, 1, 1, 0, 0, 3, IDLE, 0, 1);
        // JZ taken
        cyc(1, 9, 0, 1, 1, 0, 0, 0, F0, 0, 0);
        cyc(1, 9, 0, 1, 1, 0, 0, 1, F1, 0, 0);
        cyc(1, 9, 0, 1, 1, 0, 0, 2, F2, 0, 0);
        cyc(1, 9, 0, 1, 1, 0, 0, 3, JMP3, 0, 1);
        // OUT
        cyc(1, 5, 0, 0, 1, 0, 0, 0, F0, 0, 0);
        cyc(1, 5, 0, 0, 1, 0, 0, 1, F1, 0, 0);
        cyc(1, 5, 0, 0, 1, 0, 0, 2, F2, 0, 0);
        cyc(1, 5, 0, 0, 1, 0, 0, 3, OUT3, 0, 1);
        // LDA
        cyc(1, 4, 0, 0, 1, 0, 0, 0, F0, 0, 0);
        cyc(1, 4, 0, 0, 1, 0, 0, 1, F1, 0, 0);
        cyc(1, 4, 0, 0, 1, 0, 0, 2, F2, 0, 0);
        cyc(1, 4, 0, 0, 1, 0, 0, 3, X3_MEM, 0, 0);
        cyc(1, 4, 0, 0, 1, 0, 0, 4, LDA4, 0, 1);
        // SUB
        cyc(1, 3, 0, 0, 1, 0, 0, 0, F0, 0, 0);
        cyc(1, 3, 0, 0, 1, 0, 0, 1, F1, 0, 0);
        cyc(1, 3, 0, 0, 1, 0, 0, 2, F2, 0, 0);
        cyc(1, 3, 0, 0, 1, 0, 0, 3, X3_MEM, 0, 0);
        cyc(1, 3, 0, 0, 1, 0, 0, 4, ADD4, 0, 0);
        cyc(1, 3, 0, 0, 1, 0, 0, 5, SUB5, 0, 1);
        // STA
        cyc(1, 6, 0, 0, 1, 0, 0, 0, F0, 0, 0);
        cyc(1, 6, 0, 0, 1, 0, 0, 1, F1, 0, 0);
        cyc(1, 6, 0, 0, 1, 0, 0, 2, F2, 0, 0);
        cyc(1, 6, 0, 0, 1, 0, 0, 3, X3_MEM, 0, 0);
        cyc(1, 6, 0, 0, 1, 0, 0, 4, STA4, 0, 0);
        cyc(1, 6, 0, 0, 1, 0, 0, 5, STA5, 0, 1);
        // Opcode 15 folds to NOP
        cyc(1, 15, 0, 0, 1, 0, 0, 0, F0, 0, 0);
        cyc(1, 15, 0, 0, 1, 0, 0, 1, F1, 0, 0);
        cyc(1, 15, 0, 0, 1, 0, 0, 2, F2, 0, 1);
        // HLT, 20 cycles halted (step_i ignored there), then resume
        cyc(1, 0, 0, 0, 1, 0, 0, 0, F0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0, 0, 1, F1, 0, 0);
        cyc(1, 0, 0, 0, 1, 0, 0, 2, F2, 0, 0);
        cyc(1, 0, 0, 0, 1, 0, 0, 3, IDLE, 0, 1);
        for (int i = 0; i < 20; i++) begin
            cyc(1, 0, 0, 0, 1, logic'(i >= 5 && i < 8), 0, 9, IDLE, 1, 0);
        end
        cyc(1, 0, 0, 0, 1, 0, 1, 9, IDLE, 1, 0);
        // Single-step NOP
        cyc(1, 1, 0, 0, 0, 0, 0, 0, F0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 1, F1, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 2, F2, 0, 1);
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0, 0, 0, 10, IDLE, 0, 0);
        cyc(1, 1, 0, 0, 0, 1, 0, 10, IDLE, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, F0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 1, F1, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 2, F2, 0, 1);
        cyc(1, 1, 0, 0, 0, 0, 0, 10, IDLE, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 10, IDLE, 0, 0);
        // step_i held high: one instruction only
        cyc(1, 1, 0, 0, 0, 1, 0, 10, IDLE, 0, 0);
        cyc(1, 1, 0, 0, 0, 1, 0, 0, F0, 0, 0);
        cyc(1, 1, 0, 0, 0, 1, 0, 1, F1, 0, 0);
        cyc(1, 1, 0, 0, 0, 1, 0, 2, F2, 0, 1);
        cyc(1, 1, 0, 0, 0, 1, 0, 10, IDLE, 0, 0);
        cyc(1, 1, 0, 0, 0, 1, 0, 10, IDLE, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 10, IDLE, 0, 0);
        // run_i releases WAIT_STEP
        cyc(1, 1, 0, 0, 1, 0, 0, 10, IDLE, 0, 0);
        // Reset during T4 of STA
        cyc(1, 6, 0, 0, 1, 0, 0, 0, F0, 0, 0);
        cyc(1, 6, 0, 0, 1, 0, 0, 1, F1, 0, 0);
        cyc(1, 6, 0, 0, 1, 0, 0, 2, F2, 0, 0);
        cyc(1, 6, 0, 0, 1, 0, 0, 3, X3_MEM, 0, 0);
        cyc(0, 6, 0, 0, 1, 0, 0, 4, STA4, 0, 0);
        // Both instances leave reset together; the 6-bit one sees upper bits set
        chk6 = 1'b1;
        cyc(1, 1, 0, 0, 1, 0, 0, 8, IDLE, 0, 0);
        cyc(1, 1, 0, 0, 1, 0, 0, 0, F0, 0, 0);
        cyc(1, 1, 0, 0, 1, 0, 0, 1, F1, 0, 0);
        cyc(1, 1, 0, 0, 1, 0, 0, 2, F2, 0, 1);
        cyc(1, 1, 0, 0, 1, 0, 0, 0, F0, 0, 0);
        bus6.opcode_i = 6'h20;
        cyc(1, 1, 0, 0, 1, 0, 0, 1, F1, 0, 0);
        cyc(1, 1, 0, 0, 1, 0, 0, 2, F2, 0, 1);
        cyc(1, 1, 0, 0, 1, 0, 0, 0, F0, 0, 0);
        chk6 = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check_val("drain", 32'(q.size() + q6.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
